// File: rtl/aes_decipher_core.sv
// Iterative AES-128/192/256 inverse cipher. InvSubBytes goes byte-serially through an
// external inverse S-Box ROM; round keys come from an external memory addressed by 'round'.
module aes_decipher_core #(
    parameter int ROM_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         next,
    input  logic [1:0]   keylen,
    input  logic [127:0] block,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    output logic [127:0] new_block,
    output logic         ready,
    output logic [7:0]   rom_addr,
    input  logic [7:0]   rom_data,
    output logic         rom_ce_n,
    output logic         rom_oe_n
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_INIT, S_SHIFT, S_SUB, S_ADDKEY, S_MIX, S_DONE
    } state_t;

    localparam logic [4:0] LAT5     = 5'(ROM_LAT);
    localparam logic [4:0] SUB_LAST = 5'(16 + ROM_LAT - 1);

    state_t       r_fsm;
    state_t       w_fsmNext;
    logic [127:0] r_state;
    logic [3:0]   r_round;
    logic [3:0]   r_nr;
    logic [4:0]   r_cnt;
    logic [127:0] r_newBlock;
    logic         r_ready;
    logic [3:0]   w_nr;
    logic         w_issue;
    logic         w_capture;
    logic [3:0]   w_capIdx;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiples 9/b/d/e built from the xtime chain x2, x4, x8.
    function automatic logic [31:0] invMixCol(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int k = 0; k < 4; k++) begin
            a[k]  = c[31-8*k -: 8];
            x2[k] = xt(a[k]);
            x4[k] = xt(x2[k]);
            x8[k] = xt(x4[k]);
            m9[k] = x8[k] ^ a[k];
            mb[k] = x8[k] ^ x2[k] ^ a[k];
            md[k] = x8[k] ^ x4[k] ^ a[k];
            me[k] = x8[k] ^ x4[k] ^ x2[k];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] invMixColumns(input logic [127:0] s);
        return {invMixCol(s[127:96]), invMixCol(s[95:64]),
                invMixCol(s[63:32]),  invMixCol(s[31:0])};
    endfunction

    // Byte index is row + 4*column; row r moves right by r columns.
    function automatic logic [127:0] invShiftRows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127-8*(r+4*((c+r)%4)) -: 8] = s[127-8*(r+4*c) -: 8];
            end
        end
        return o;
    endfunction

    always_comb begin
        case (keylen)
            2'd1:    w_nr = 4'd12;
            2'd2:    w_nr = 4'd14;
            default: w_nr = 4'd10;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_fsm <= S_IDLE;
        else       r_fsm <= w_fsmNext;
    end

    always_comb begin
        w_fsmNext = r_fsm;
        case (r_fsm)
            S_IDLE:   if (next) w_fsmNext = S_LOAD;
            S_LOAD:   w_fsmNext = S_INIT;
            S_INIT:   w_fsmNext = S_SHIFT;
            S_SHIFT:  w_fsmNext = S_SUB;
            S_SUB:    if (r_cnt == SUB_LAST) w_fsmNext = S_ADDKEY;
            S_ADDKEY: w_fsmNext = (r_round == 4'd0) ? S_DONE : S_MIX;
            S_MIX:    w_fsmNext = S_SHIFT;
            S_DONE:   w_fsmNext = S_IDLE;
            default:  w_fsmNext = S_IDLE;
        endcase
    end

    // Addresses go out in SUB cycles 0..15; data for byte k lands ROM_LAT cycles later.
    always_comb begin
        w_issue   = (r_fsm == S_SUB) && !r_cnt[4];
        w_capture = (r_fsm == S_SUB) && (r_cnt >= LAT5);
        w_capIdx  = 4'(r_cnt - LAT5);
        rom_addr  = w_issue ? r_state[{~r_cnt[3:0], 3'b000} +: 8] : 8'h00;
        rom_ce_n  = !w_issue;
        rom_oe_n  = !w_issue;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= '0;
            r_round    <= '0;
            r_nr       <= '0;
            r_cnt      <= '0;
            r_newBlock <= '0;
            r_ready    <= 1'b1;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (next) begin
                        r_state <= block;
                        r_nr    <= w_nr;
                        r_round <= w_nr;
                        r_ready <= 1'b0;
                    end
                end
                S_INIT: begin
                    r_state <= r_state ^ round_key;
                    r_round <= r_nr - 4'd1;
                end
                S_SHIFT: begin
                    r_state <= invShiftRows(r_state);
                    r_cnt   <= '0;
                end
                S_SUB: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (w_capture) r_state[{~w_capIdx, 3'b000} +: 8] <= rom_data;
                end
                S_ADDKEY: r_state <= r_state ^ round_key;
                S_MIX: begin
                    r_state <= invMixColumns(r_state);
                    r_round <= r_round - 4'd1;
                end
                S_DONE: begin
                    r_newBlock <= r_state;
                    r_ready    <= 1'b1;
                    r_round    <= '0;
                end
                default: ;
            endcase
        end
    end

    assign round     = r_round;
    assign new_block = r_newBlock;
    assign ready     = r_ready;

endmodule

// File: tb/tb_aes_decipher_core.sv
// Bench for aes_decipher_core: two DUTs (ROM_LAT 1 and 2) with ROM and registered key-memory
// models; results checked against FIPS-197 vectors and a byte-array AES reference model.
module tb_aes_decipher_core;

    localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f00000000000000000000000000000000;
    localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f10111213141516170000000000000000;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;

    typedef struct {
        int           dut;
        logic [255:0] key;
        logic [1:0]   kl;
        logic [127:0] ct;
        logic [127:0] pt;
        int           lat;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         nextS [2];
    logic [1:0]   keylenS [2];
    logic [127:0] blockS [2];
    logic [3:0]   round0, round1;
    logic [127:0] rk0, rk1, newBlock0, newBlock1;
    logic         ready0, ready1, ceN0, ceN1, oeN0, oeN1;
    logic [7:0]   romAddr0, romAddr1, romData0, romData1;

    logic [7:0]   sbox [256];
    logic [7:0]   invSbox [256];
    logic [127:0] schedRk [16];
    int           schedNr;
    logic [127:0] rkTab [2][16];
    logic [7:0]   pa0 [4];
    logic [7:0]   pa1 [4];
    logic         pv0 [4];
    logic         pv1 [4];
    int           lookups0 = 0;
    int           lookups1 = 0;
    int           roundSeq [$];
    int           total = 0;
    int           bad = 0;
    vec_t         vecs [7];

    aes_decipher_core #(.ROM_LAT(1)) dut0 (
        .clk(clk), .reset(reset), .next(nextS[0]), .keylen(keylenS[0]), .block(blockS[0]),
        .round(round0), .round_key(rk0), .new_block(newBlock0), .ready(ready0),
        .rom_addr(romAddr0), .rom_data(romData0), .rom_ce_n(ceN0), .rom_oe_n(oeN0));

    aes_decipher_core #(.ROM_LAT(2)) dut1 (
        .clk(clk), .reset(reset), .next(nextS[1]), .keylen(keylenS[1]), .block(blockS[1]),
        .round(round1), .round_key(rk1), .new_block(newBlock1), .ready(ready1),
        .rom_addr(romAddr1), .rom_data(romData1), .rom_ce_n(ceN1), .rom_oe_n(oeN1));

    // Registered key memory and a ROM whose data appears ROM_LAT edges after the address.
    always @(posedge clk) begin
        rk0    <= rkTab[0][round0];
        pa0[0] <= romAddr0;
        pv0[0] <= !ceN0 && !oeN0;
        for (int i = 1; i < 4; i++) begin
            pa0[i] <= pa0[i-1];
            pv0[i] <= pv0[i-1];
        end
        if (!ceN0) lookups0 <= lookups0 + 1;
    end

    always @(posedge clk) begin
        rk1    <= rkTab[1][round1];
        pa1[0] <= romAddr1;
        pv1[0] <= !ceN1 && !oeN1;
        for (int i = 1; i < 4; i++) begin
            pa1[i] <= pa1[i-1];
            pv1[i] <= pv1[i-1];
        end
        if (!ceN1) lookups1 <= lookups1 + 1;
    end

    assign romData0 = pv0[0] ? invSbox[pa0[0]] : 8'h00;
    assign romData1 = pv1[1] ? invSbox[pa1[1]] : 8'h00;

    function automatic logic readyOf(input int d);
        return (d == 1) ? ready1 : ready0;
    endfunction
    function automatic logic [127:0] nbOf(input int d);
        return (d == 1) ? newBlock1 : newBlock0;
    endfunction
    function automatic logic [3:0] roundOf(input int d);
        return (d == 1) ? round1 : round0;
    endfunction
    function automatic int lookOf(input int d);
        return (d == 1) ? lookups1 : lookups0;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // Forward S-Box from its definition: multiplicative inverse then the affine map.
    function automatic logic [7:0] sboxCalc(input logic [7:0] b);
        logic [7:0] inv = 8'h00;
        if (b != 8'h00)
            for (int j = 1; j < 256; j++)
                if (gmul(b, 8'(j)) == 8'h01) inv = 8'(j);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic buildSchedule(input logic [255:0] key, input logic [1:0] kl);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        int          nk;
        nk = (kl == 2'd1) ? 6 : (kl == 2'd2) ? 8 : 4;
        schedNr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        rcon = 8'h01;
        for (int i = nk; i < 4 * (schedNr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subWord({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subWord(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            schedRk[r] = (r <= schedNr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    function automatic logic [127:0] modelDecrypt(input logic [127:0] ct);
        logic [7:0]   st [16];
        logic [7:0]   tmp [16];
        logic [7:0]   a [4];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) st[i] = ct[127-8*i -: 8] ^ schedRk[schedNr][127-8*i -: 8];
        for (int rnd = schedNr - 1; rnd >= 0; rnd--) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) tmp[r+4*((c+r)%4)] = st[r+4*c];
            for (int i = 0; i < 16; i++) st[i] = invSbox[tmp[i]] ^ schedRk[rnd][127-8*i -: 8];
            if (rnd != 0) begin
                for (int c = 0; c < 4; c++) begin
                    for (int k = 0; k < 4; k++) a[k] = st[4*c+k];
                    for (int k = 0; k < 4; k++)
                        st[4*c+k] = gmul(8'h0e, a[k]) ^ gmul(8'h0b, a[(k+1)%4])
                                  ^ gmul(8'h0d, a[(k+2)%4]) ^ gmul(8'h09, a[(k+3)%4]);
                end
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = st[i];
        return o;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Loads the key memory, presents the request and returns #1 after the accepting edge.
    task automatic applyStimulus(input int d, input logic [255:0] key, input logic [1:0] kl,
                                 input logic [127:0] ct, input bit holdNext);
        buildSchedule(key, kl);
        for (int r = 0; r < 16; r++) rkTab[d][r] = schedRk[r];
        @(negedge clk);
        nextS[d]   = 1'b1;
        keylenS[d] = kl;
        blockS[d]  = ct;
        @(posedge clk);
        #1;
        if (!holdNext) begin
            nextS[d]   = 1'b0;
            blockS[d]  = {$urandom, $urandom, $urandom, $urandom};
            keylenS[d] = 2'($urandom);
        end
        checkOutput("accept_ready_low", 128'(readyOf(d)), 128'(0));
    endtask

    task automatic waitDone(input int d, input int pulseAt, output int lat, output bit to);
        logic [3:0] lastR;
        lat = 0;
        to = 1'b0;
        roundSeq.delete();
        lastR = roundOf(d);
        roundSeq.push_back(int'(lastR));
        forever begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == pulseAt) begin
                nextS[d]  = 1'b1;
                blockS[d] = {$urandom, $urandom, $urandom, $urandom};
            end else if (lat == pulseAt + 1) begin
                nextS[d] = 1'b0;
            end
            if (roundOf(d) != lastR) begin
                lastR = roundOf(d);
                roundSeq.push_back(int'(lastR));
            end
            if (readyOf(d)) break;
            if (lat >= 3000) begin
                to = 1'b1;
                break;
            end
        end
        if (to) begin
            total++;
            bad++;
            $display("[TB] FAIL ready_timeout: actual=no ready after %0d cycles required=ready", lat);
        end
    endtask

    task automatic runCheck(input string tag, input int d, input logic [255:0] key,
                            input logic [1:0] kl, input logic [127:0] ct, input logic [127:0] pt,
                            input int expLat, input int pulseAt, input bit holdNext);
        int lk0, lat, nr, j;
        bit to;
        nr  = (kl == 2'd1) ? 12 : (kl == 2'd2) ? 14 : 10;
        lk0 = lookOf(d);
        applyStimulus(d, key, kl, ct, holdNext);
        waitDone(d, pulseAt, lat, to);
        checkOutput({tag, "_pt"}, nbOf(d), pt);
        checkOutput({tag, "_lat"}, 128'(lat), 128'(expLat));
        checkOutput({tag, "_lookups"}, 128'(lookOf(d) - lk0), 128'(nr * 16));
        checkOutput({tag, "_rounds_len"}, 128'(roundSeq.size()), 128'(nr + 1));
        j = -1;
        for (int i = 0; i < roundSeq.size() && i <= nr; i++)
            if (j < 0 && roundSeq[i] != nr - i) j = i;
        if (j < 0) j = (roundSeq.size() - 1 < nr) ? roundSeq.size() - 1 : nr;
        checkOutput({tag, "_rounds_val"}, 128'(roundSeq[j]), 128'(nr - j));
    endtask

    initial begin
        int lat, d, nr, lk;
        bit to;
        logic [255:0] key;
        logic [127:0] ct, exp;
        logic [1:0] kl;

        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            nextS[i]   = 1'b0;
            keylenS[i] = 2'd0;
            blockS[i]  = '0;
            for (int r = 0; r < 16; r++) rkTab[i][r] = '0;
        end
        for (int v = 0; v < 256; v++) sbox[v] = sboxCalc(8'(v));
        for (int v = 0; v < 256; v++) invSbox[sbox[v]] = 8'(v);

        vecs[0] = '{0, K128, 2'd0, CT1, PT, 202};
        vecs[1] = '{0, K192, 2'd1, CT2, PT, 242};
        vecs[2] = '{1, K256, 2'd2, CT3, PT, 296};
        vecs[3] = '{0, K128, 2'd3, CT1, PT, 202};
        vecs[4] = '{1, K128, 2'd0, CT1, PT, 212};
        vecs[5] = '{1, K192, 2'd1, CT2, PT, 254};
        vecs[6] = '{0, K256, 2'd2, CT3, PT, 282};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("rst_ready0", 128'(ready0), 128'(1));
        checkOutput("rst_newblock0", newBlock0, 128'h0);
        checkOutput("rst_round0", 128'(round0), 128'(0));
        checkOutput("rst_romaddr0", 128'(romAddr0), 128'(0));
        checkOutput("rst_ce0", 128'({ceN0, oeN0}), 128'(3));
        checkOutput("rst_ready1", 128'(ready1), 128'(1));
        checkOutput("rst_newblock1", newBlock1, 128'h0);
        checkOutput("rst_ce1", 128'({ceN1, oeN1}), 128'(3));

        for (int i = 0; i < 7; i++)
            runCheck($sformatf("vec%0d", i), vecs[i].dut, vecs[i].key, vecs[i].kl,
                     vecs[i].ct, vecs[i].pt, vecs[i].lat, -1, 1'b0);

        // Abort mid-operation: new_block held the previous result until the reset hit.
        applyStimulus(0, K128, 2'd0, CT1, 1'b0);
        repeat (50) @(posedge clk);
        #1;
        checkOutput("busy_newblock_hold", newBlock0, PT);
        checkOutput("busy_rom_active", 128'(ceN0), 128'(0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("abort_ready", 128'(ready0), 128'(1));
        checkOutput("abort_ce", 128'({ceN0, oeN0}), 128'(3));
        checkOutput("abort_newblock", newBlock0, 128'h0);
        checkOutput("abort_round", 128'(round0), 128'(0));
        runCheck("rerun", 0, K128, 2'd0, CT1, PT, 202, -1, 1'b0);

        // next pulsed while busy must neither restart nor queue an operation.
        runCheck("busy_next", 0, K128, 2'd0, CT1, PT, 202, 30, 1'b0);
        lk = lookups0;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("no_queue_ready", 128'(ready0), 128'(1));
        checkOutput("no_queue_lookups", 128'(lookups0 - lk), 128'(0));

        // next held across DONE: the next op starts one cycle after ready rises.
        runCheck("hold_first", 0, K192, 2'd1, CT2, PT, 242, -1, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("b2b_accept", 128'(ready0), 128'(0));
        nextS[0] = 1'b0;
        waitDone(0, -1, lat, to);
        checkOutput("b2b_pt", newBlock0, PT);
        checkOutput("b2b_lat", 128'(lat), 128'(242));

        for (int i = 0; i < 8; i++) begin
            d   = i % 2;
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            ct  = {$urandom, $urandom, $urandom, $urandom};
            kl  = 2'($urandom_range(0, 3));
            nr  = (kl == 2'd1) ? 12 : (kl == 2'd2) ? 14 : 10;
            buildSchedule(key, kl);
            exp = modelDecrypt(ct);
            repeat ($urandom_range(0, 5)) @(posedge clk);
            runCheck($sformatf("rand%0d", i), d, key, kl, ct, exp, nr * (19 + d + 1) + 2,
                     (i >= 4) ? int'($urandom_range(1, 150)) : -1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
